// File: rtl/seq_div.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one
// quotient bit per clock, with a start/done handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// CALC  | iterating, one quotient bit per edge, busy high
// FIN   | done pulse cycle; a new start here loads back-to-back
//
// The dividend shift register also collects the quotient bits: each
// iteration takes the dividend MSB into the partial remainder and
// shifts the new quotient bit into the LSB. After DW edges it holds the
// full quotient. This requires DW >= 2.
module seq_div #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t        state;
  logic [DW-1:0] dvd_sr;
  logic [VW-1:0] dvs;
  logic [VW:0]   prem;
  logic [CW-1:0] cnt;

  logic [VW:0]   shifted;
  logic [VW:0]   trial;
  logic          q_bit;
  logic [VW:0]   prem_next;
  logic [DW-1:0] dvd_next;

  // One restoring step. The partial remainder stays below the divisor, so
  // its MSB is always zero and only the low VW bits are shifted up.
  always_comb begin
    shifted   = {prem[VW-1:0], dvd_sr[DW-1]};
    trial     = shifted - {1'b0, dvs};
    q_bit     = ~trial[VW];
    prem_next = q_bit ? trial : shifted;
    dvd_next  = {dvd_sr[DW-2:0], q_bit};
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_sr      <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            dvd_sr <= dividend;
            dvs    <= divisor;
            prem   <= '0;
            cnt    <= CW'(DW);
            if (divisor == '0) begin
              // No iteration needed: report saturated quotient at once.
              state       <= FIN;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        CALC: begin
          // start is ignored here; operands stay as captured.
          prem   <= prem_next;
          dvd_sr <= dvd_next;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient    <= dvd_next;
            remainder   <= prem_next[VW-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= FIN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
